// File: rtl/apb_rr_master.sv
// apb_rr_master: two-requester APB master with round-robin arbitration.
// Each requester hands over one command through a valid/ready pulse handshake.
// The master runs the APB SETUP/ACCESS phases and returns a one-cycle
// completion pulse, with read data, to the owning requester.
// Optional feature macro: APB_TIMEOUT_EN. When defined, an ACCESS phase is
// aborted with rsp_err = 1 after TIMEOUT_CYCLES cycles without pready.
module apb_rr_master #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    PRESETn,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_done,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    pwrite,
    output logic                    psel,
    output logic                    penable,
    output logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e state;
    logic   owner;       // requester whose transfer is in flight
    logic   last_owner;  // requester served most recently; loses the next tie

    // A single requester wins outright; on a tie the one not served last wins.
    function automatic logic pick(input logic [1:0] v, input logic last);
        return (v == 2'b11) ? ~last : v[1];
    endfunction

    logic                  arb_any;
    logic                  win;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  win_write;

    assign arb_any = |req_valid;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt;
    logic [CntW-1:0] tmo_cnt_inc;
    logic            tmo_hit;

    assign tmo_cnt_inc = tmo_cnt + 1'b1;
    assign tmo_hit     = (tmo_cnt_inc == CntW'(TIMEOUT_CYCLES));
`endif

    // Winner selection and payload mux; in ACCESS the owner of the finishing
    // transfer becomes the new last_owner, so arbitrate against it directly.
    always_comb begin
        win       = (state == StAccess) ? pick(req_valid, owner) : pick(req_valid, last_owner);
        win_addr  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        win_wdata = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        win_write = win ? req_write[1] : req_write[0];
    end

    // Main FSM with registered APB and response outputs.
    always_ff @(posedge pclk or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= StIdle;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            req_ready  <= '0;
            rsp_done   <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            req_ready <= '0;
            rsp_done  <= '0;
            case (state)
                StIdle: begin
                    if (arb_any) begin
                        paddr     <= win_addr;
                        pwdata    <= win_wdata;
                        pwrite    <= win_write;
                        owner     <= win;
                        req_ready <= win ? 2'b10 : 2'b01;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        state     <= StSetup;
                    end
                end
                StSetup: begin
                    penable <= 1'b1;
                    state   <= StAccess;
`ifdef APB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                StAccess: begin
                    if (pready) begin
                        rsp_rdata  <= pwrite ? '0 : prdata;
                        rsp_done   <= owner ? 2'b10 : 2'b01;
                        rsp_err    <= 1'b0;
                        last_owner <= owner;
                        penable    <= 1'b0;
                        if (arb_any) begin
                            // Back-to-back: go straight to SETUP with psel held.
                            paddr     <= win_addr;
                            pwdata    <= win_wdata;
                            pwrite    <= win_write;
                            owner     <= win;
                            req_ready <= win ? 2'b10 : 2'b01;
                            state     <= StSetup;
                        end else begin
                            psel  <= 1'b0;
                            state <= StIdle;
                        end
`ifdef APB_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        // Abort; never chains into a back-to-back transfer.
                        rsp_rdata  <= '0;
                        rsp_done   <= owner ? 2'b10 : 2'b01;
                        rsp_err    <= 1'b1;
                        last_owner <= owner;
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        state      <= StIdle;
                    end else begin
                        tmo_cnt <= tmo_cnt_inc;
`endif
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= StIdle;
                end
            endcase
        end
    end

endmodule
